// File: rtl/contador_arbitro.sv
// contador_arbitro: one shared 8-bit up/down counter served to NUM_REQ
// requesters through a round-robin arbiter and a two-state IDLE/EXEC FSM.
// Optional build macro CONTADOR_ARBITRO_SATURATE_EN: inc/dec clamp at 255/0
// and an extra `sat` output pulses alongside ack for a clamped command.
module contador_arbitro #(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [7:0]  RESET_VALUE = 8'd106
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   op,
    input  logic [8*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             count,
    output logic [2:0]             grant_id,
`ifdef CONTADOR_ARBITRO_SATURATE_EN
    output logic                   sat,
`endif
    output logic                   busy
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned SRC_W = 4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_q;
    logic [1:0]         op_q;
    logic [7:0]         data_q;

    // Inputs widened to the full 8-requester space so every select index is exact width
    logic [7:0]         req_pad;
    logic [15:0]        op_pad;
    logic [63:0]        data_pad;

    logic               found_c;
    logic [IDX_W-1:0]   win_c;
    logic [SRC_W-1:0]   cand_c;
    logic [1:0]         op_sel_c;
    logic [7:0]         data_sel_c;
    logic [7:0]         cnt_exec_c;
    logic [NUM_REQ-1:0] ack_c;
    logic [IDX_W-1:0]   ptr_next_c;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
    logic               sat_exec_c;
`endif

    assign req_pad  = 8'(req);
    assign op_pad   = 16'(op);
    assign data_pad = 64'(data);

    // Round-robin search: pointer index first, then ascending with wrap
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = SRC_W'({1'b0, ptr}) + SRC_W'(i);
            if (cand_c >= SRC_W'(NUM_REQ)) begin
                cand_c = cand_c - SRC_W'(NUM_REQ);
            end
            if (!found_c && req_pad[cand_c[IDX_W-1:0]]) begin
                found_c = 1'b1;
                win_c   = cand_c[IDX_W-1:0];
            end
        end
    end

    // Winner's command fields, captured only at grant
    always_comb begin
        op_sel_c   = op_pad[{win_c, 1'b0} +: 2];
        data_sel_c = data_pad[{win_c, 3'b000} +: 8];
    end

    // Count update for the latched command
    always_comb begin
        cnt_exec_c = count;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
        sat_exec_c = 1'b0;
`endif
        case (op_q)
            OP_INC: begin
`ifdef CONTADOR_ARBITRO_SATURATE_EN
                if (count == 8'hFF) sat_exec_c = 1'b1;
                else                cnt_exec_c = count + 8'd1;
`else
                cnt_exec_c = count + 8'd1;
`endif
            end
            OP_DEC: begin
`ifdef CONTADOR_ARBITRO_SATURATE_EN
                if (count == 8'h00) sat_exec_c = 1'b1;
                else                cnt_exec_c = count - 8'd1;
`else
                cnt_exec_c = count - 8'd1;
`endif
            end
            OP_LOAD: cnt_exec_c = data_q;
            OP_NOP:  cnt_exec_c = count;
            default: cnt_exec_c = count;
        endcase
    end

    // One-hot ack for the latched winner and the pointer that follows it
    always_comb begin
        ack_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ack_c[i] = (win_q == IDX_W'(i));
        end
        ptr_next_c = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
    end

    // FSM, shared count and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= RESET_VALUE;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr      <= '0;
            win_q    <= '0;
            op_q     <= OP_NOP;
            data_q   <= '0;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
            sat      <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
            sat <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found_c) begin
                        win_q    <= win_c;
                        op_q     <= op_sel_c;
                        data_q   <= data_sel_c;
                        grant_id <= win_c;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    count <= cnt_exec_c;
                    ack   <= ack_c;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
                    sat   <= sat_exec_c;
`endif
                    ptr   <= ptr_next_c;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contador_arbitro.sv
// Bench for contador_arbitro: vector table plus scoreboard queue, with
// hand-written sequences for back-to-back round robin and reset mid-command.
module tb_contador_arbitro;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [8*N-1:0] data;
    logic [N-1:0]   ack;
    logic [7:0]     count;
    logic [2:0]     grant_id;
    logic           busy;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
    logic           sat;
`endif

    contador_arbitro #(.NUM_REQ(N), .RESET_VALUE(8'd106)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op       (op),
        .data     (data),
        .ack      (ack),
        .count    (count),
        .grant_id (grant_id),
`ifdef CONTADOR_ARBITRO_SATURATE_EN
        .sat      (sat),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] win;
        logic [7:0] cnt;
        logic       sat;
    } exp_t;

    typedef struct {
        logic [3:0]  r;
        logic [7:0]  o;
        logic [31:0] d;
        logic [2:0]  win;
        logic [7:0]  cnt_wrap;
        logic [7:0]  cnt_sat;
        logic        sat;
    } vec_t;

    exp_t     sb[$];
    int       n_vec = 0;
    int       n_err = 0;
    logic [N-1:0] prev_ack = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pick_cnt(input logic [7:0] wrap_v, input logic [7:0] sat_v);
`ifdef CONTADOR_ARBITRO_SATURATE_EN
        return sat_v;
`else
        return wrap_v;
`endif
    endfunction

    // Scoreboard: every ack pops one expected grant and checks the outputs
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] exp_ack;
        if (rst_n) begin
            if (ack != '0) begin
                check("ack_back_to_back", 32'(prev_ack), 32'h0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got %0h expected none at %0t", ack, $time);
                end else begin
                    e = sb.pop_front();
                    exp_ack = '0;
                    exp_ack[e.win] = 1'b1;
                    check("ack_onehot", 32'(ack), 32'(exp_ack));
                    check("grant_id", 32'(grant_id), 32'(e.win));
                    check("count", 32'(count), 32'(e.cnt));
                    check("busy_at_ack", 32'(busy), 32'h0);
`ifdef CONTADOR_ARBITRO_SATURATE_EN
                    check("sat", 32'(sat), 32'(e.sat));
`endif
                end
            end
            prev_ack = ack;
        end else begin
            prev_ack = '0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        data  = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd106);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        rst_n = 1'b1;
    endtask

    // Drive one command set, expect a single grant two cycles later
    task automatic apply(input vec_t v);
        exp_t e;
        int   waited;
        bit   got;
        e.win = v.win;
        e.cnt = pick_cnt(v.cnt_wrap, v.cnt_sat);
        e.sat = v.sat;
        sb.push_back(e);
        @(negedge clk);
        req  = v.r;
        op   = v.o;
        data = v.d;
        waited = 0;
        got    = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            waited++;
            if (ack != '0) got = 1;
        end
        req = '0;
        check("ack_latency", 32'(waited), 32'd2);
    endtask

    vec_t tbl[10];

    initial begin
        int   gap;
        bit   got;
        vec_t v;

        tbl[0] = '{4'b0010, 8'h04, 32'h0000_0000, 3'd1, 8'd107, 8'd107, 1'b0};
        tbl[1] = '{4'b0010, 8'h04, 32'h0000_0000, 3'd1, 8'd108, 8'd108, 1'b0};
        tbl[2] = '{4'b0100, 8'h30, 32'h00FF_0000, 3'd2, 8'hFF,  8'hFF,  1'b0};
        tbl[3] = '{4'b0001, 8'h01, 32'h0000_0000, 3'd0, 8'h00,  8'hFF,  1'b1};
        tbl[4] = '{4'b1000, 8'hC0, 32'h0000_0000, 3'd3, 8'h00,  8'h00,  1'b0};
        tbl[5] = '{4'b1000, 8'h80, 32'h0000_0000, 3'd3, 8'hFF,  8'h00,  1'b1};
        tbl[6] = '{4'b1001, 8'h40, 32'h0000_0000, 3'd0, 8'hFF,  8'h00,  1'b0};
        tbl[7] = '{4'b1001, 8'hC0, 32'h5A00_0000, 3'd3, 8'h5A,  8'h5A,  1'b0};
        tbl[8] = '{4'b0110, 8'h18, 32'h0000_0000, 3'd1, 8'h59,  8'h59,  1'b0};
        tbl[9] = '{4'b0110, 8'h18, 32'h0000_0000, 3'd2, 8'h5A,  8'h5A,  1'b0};

        do_reset();

        // Idle after reset: nothing moves
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_count", 32'(count), 32'd106);
            check("idle_ack", 32'(ack), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
        end

        // All four requesting inc continuously: grants 0,1,2,3,0 every other cycle
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.win = 3'(k % 4);
            e.cnt = 8'(107 + k);
            e.sat = 1'b0;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 4'hF;
        op  = 8'h55;
        for (int g = 0; g < 5; g++) begin
            gap = 0;
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                gap++;
                if (ack != '0) got = 1;
            end
            check("rr_gap", 32'(gap), 32'd2);
        end
        req = '0;
        repeat (2) @(negedge clk);
        check("rr_queue_drained", 32'(sb.size()), 32'd0);

        // Vector table from a fresh reset (pointer 0, count 106)
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = tbl[i];
            apply(v);
        end
        repeat (2) @(negedge clk);

        // Reset mid-EXEC of a load: discarded, no ack, pointer back to 0
        req  = 4'b0100;
        op   = 8'h30;
        data = 32'h0005_0000;
        @(posedge clk);
        #1;
        check("exec_busy", 32'(busy), 32'h1);
        check("exec_grant_id", 32'(grant_id), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd106);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_grant_id", 32'(grant_id), 32'h0);
        req  = '0;
        op   = '0;
        data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_count", 32'(count), 32'd106);
        v = '{4'b1001, 8'h41, 32'h0, 3'd0, 8'd107, 8'd107, 1'b0};
        apply(v);
        repeat (3) @(negedge clk);
        check("final_queue_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
